// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes one RV32 integer/branch/memory instruction into registered
// ALU operands and control, held in a single-entry valid/ready pipeline register.
module alu_issue_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic [31:0]      imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      SrcA,
  output logic [31:0]      SrcB,
  output logic [2:0]       ALUControl,
  output logic             is_branch,
  output logic             branch_ne,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_count
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  typedef struct packed {
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [2:0]  alu_ctrl;
    logic        is_branch;
    logic        branch_ne;
    logic        illegal;
  } issue_t;

  issue_t             slot_d, slot_q;
  logic               out_valid_d, out_valid_q;
  logic [CNT_W-1:0]   count_d, count_q;

  logic               legal;
  logic               use_imm;
  logic [2:0]         alu_sel;
  logic               br, br_ne;
  logic               accept, transfer;

  // Handshake: a beat moves on an edge where valid && ready are both high; valid never
  // drops and payload never changes while the consumer is not ready.
  assign in_ready = !rst_n || !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = out_valid_q && out_ready;

  always_comb begin
    legal   = 1'b0;
    use_imm = 1'b0;
    alu_sel = ALU_ADD;
    br      = 1'b0;
    br_ne   = 1'b0;
    unique case (opcode)
      OP_R: begin
        legal = 1'b1;
        unique case (funct3)
          3'b000:  alu_sel = funct7b5 ? ALU_SUB : ALU_ADD;
          3'b111:  alu_sel = ALU_AND;
          3'b110:  alu_sel = ALU_OR;
          3'b010:  alu_sel = ALU_SLT;
          default: legal = 1'b0;
        endcase
      end
      OP_I: begin
        legal   = 1'b1;
        use_imm = 1'b1;
        unique case (funct3)
          3'b000:  alu_sel = ALU_ADD;
          3'b111:  alu_sel = ALU_AND;
          3'b110:  alu_sel = ALU_OR;
          3'b010:  alu_sel = ALU_SLT;
          default: legal = 1'b0;
        endcase
      end
      OP_LOAD, OP_STORE: begin
        legal   = 1'b1;
        use_imm = 1'b1;
      end
      OP_BRANCH: begin
        alu_sel = ALU_SUB;
        br      = 1'b1;
        unique case (funct3)
          3'b000:  legal = 1'b1;
          3'b001: begin
            legal = 1'b1;
            br_ne = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Unsupported encodings still issue, but with every control/operand field zeroed.
  always_comb begin
    slot_d = '0;
    if (legal) begin
      slot_d.src_a     = rs1_data;
      slot_d.src_b     = use_imm ? imm : rs2_data;
      slot_d.alu_ctrl  = alu_sel;
      slot_d.is_branch = br;
      slot_d.branch_ne = br_ne;
    end else begin
      slot_d.illegal   = 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    count_d     = transfer ? count_q + 1'b1 : count_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
    end else if (transfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      slot_q      <= '0;
      count_q     <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
      if (accept && !flush) begin
        slot_q <= slot_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign SrcA        = slot_q.src_a;
  assign SrcB        = slot_q.src_b;
  assign ALUControl  = slot_q.alu_ctrl;
  assign is_branch   = slot_q.is_branch;
  assign branch_ne   = slot_q.branch_ne;
  assign illegal     = slot_q.illegal;
  assign issue_count = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: instruction-level reference model checked every cycle,
// plus directed scenarios with literal expectations; a 4-bit-counter copy checks wrap.
module tb_alu_issue_stage;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, funct7b5 = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0;

  logic        in_ready, out_valid, is_branch, branch_ne, illegal;
  logic [31:0] SrcA, SrcB;
  logic [2:0]  ALUControl;
  logic [15:0] issue_count;

  logic        in_ready4, out_valid4, is_branch4, branch_ne4, illegal4;
  logic [31:0] SrcA4, SrcB4;
  logic [2:0]  ALUControl4;
  logic [3:0]  issue_count4;

  alu_issue_stage #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .SrcA(SrcA), .SrcB(SrcB),
    .ALUControl(ALUControl), .is_branch(is_branch), .branch_ne(branch_ne),
    .illegal(illegal), .issue_count(issue_count)
  );

  alu_issue_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .flush(flush),
    .out_valid(out_valid4), .out_ready(out_ready), .SrcA(SrcA4), .SrcB(SrcB4),
    .ALUControl(ALUControl4), .is_branch(is_branch4), .branch_ne(branch_ne4),
    .illegal(illegal4), .issue_count(issue_count4)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  alu;
    logic        br;
    logic        ne;
    logic        ill;
  } exp_t;

  // Instruction semantics by mnemonic: pick the operation, then the operand source.
  function automatic exp_t model_decode(input logic [6:0] op, input logic [2:0] f3,
                                        input logic f7, input logic [31:0] r1,
                                        input logic [31:0] r2, input logic [31:0] im);
    exp_t e;
    string mn;
    mn = "";
    if (op == OP_R && f3 == 3'd0) mn = f7 ? "sub" : "add";
    if (op == OP_R && f3 == 3'd7) mn = "and";
    if (op == OP_R && f3 == 3'd6) mn = "or";
    if (op == OP_R && f3 == 3'd2) mn = "slt";
    if (op == OP_I && f3 == 3'd0) mn = "addi";
    if (op == OP_I && f3 == 3'd7) mn = "andi";
    if (op == OP_I && f3 == 3'd6) mn = "ori";
    if (op == OP_I && f3 == 3'd2) mn = "slti";
    if (op == OP_LD || op == OP_ST) mn = "mem";
    if (op == OP_BR && f3 == 3'd0) mn = "beq";
    if (op == OP_BR && f3 == 3'd1) mn = "bne";
    e = '{a: 32'd0, b: 32'd0, alu: 3'd0, br: 1'b0, ne: 1'b0, ill: 1'b0};
    case (mn)
      "add", "addi", "mem": e.alu = 3'd0;
      "sub", "beq", "bne":  e.alu = 3'd1;
      "and", "andi":        e.alu = 3'd2;
      "or", "ori":          e.alu = 3'd3;
      "slt", "slti":        e.alu = 3'd4;
      default:              e.ill = 1'b1;
    endcase
    if (!e.ill) begin
      e.a  = r1;
      e.b  = (mn == "addi" || mn == "andi" || mn == "ori" || mn == "slti" || mn == "mem")
             ? im : r2;
      e.br = (mn == "beq" || mn == "bne");
      e.ne = (mn == "bne");
    end
    return e;
  endfunction

  logic        m_init = 1'b0;
  logic        m_rst_vals = 1'b0;
  exp_t        m_q[$];          // at most one held instruction
  exp_t        m_last;
  logic [31:0] m_xfers = '0;

  always @(posedge clk) begin
    logic can_take, moved;
    if (!rst_n) begin
      m_init     = 1'b1;
      m_rst_vals = 1'b1;
      m_q.delete();
      m_last  = '{a: 32'd0, b: 32'd0, alu: 3'd0, br: 1'b0, ne: 1'b0, ill: 1'b0};
      m_xfers = '0;
    end else if (m_init) begin
      moved    = (m_q.size() == 1) && out_ready;
      can_take = (m_q.size() == 0) || out_ready;
      if (moved) begin
        void'(m_q.pop_front());
        m_xfers = m_xfers + 1;
      end
      if (flush) begin
        m_q.delete();
      end else if (in_valid && can_take) begin
        m_last = model_decode(opcode, funct3, funct7b5, rs1_data, rs2_data, imm);
        m_q.push_back(m_last);
        m_rst_vals = 1'b0;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_init) begin
      check("in_ready", {31'd0, in_ready}, {31'd0, (!rst_n || m_q.size() == 0 || out_ready)});
      check("out_valid", {31'd0, out_valid}, {31'd0, (m_q.size() == 1)});
      check("issue_count", {16'd0, issue_count}, {16'd0, m_xfers[15:0]});
      check("issue_count4", {28'd0, issue_count4}, {28'd0, m_xfers[3:0]});
      if (m_q.size() == 1 || m_rst_vals) begin
        check("SrcA", SrcA, m_last.a);
        check("SrcB", SrcB, m_last.b);
        check("ALUControl", {29'd0, ALUControl}, {29'd0, m_last.alu});
        check("ctl_bits", {29'd0, is_branch, branch_ne, illegal},
              {29'd0, m_last.br, m_last.ne, m_last.ill});
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [6:0] op, input logic [2:0] f3,
                      input logic f7, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] im, input logic ordy, input logic fl);
    in_valid = v;  opcode = op;  funct3 = f3;  funct7b5 = f7;
    rs1_data = a;  rs2_data = b; imm = im;     out_ready = ordy; flush = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, ordy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [6:0] op; logic [2:0] f3; logic f7; } ins_t;
  ins_t tbl[12];

  initial begin
    // Reset with garbage traffic present
    rst_n = 1'b0;
    step(1'b1, OP_R, 3'd0, 1'b0, 32'h11, 32'h22, 32'h33, 1'b1, 1'b0);
    step(1'b1, OP_R, 3'd0, 1'b0, 32'h11, 32'h22, 32'h33, 1'b1, 1'b0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_count", {16'd0, issue_count}, 32'd0);
    check("rst_srca", SrcA, 32'd0);
    rst_n = 1'b1;

    // R-type SUB 5 - 7
    step(1'b1, OP_R, 3'd0, 1'b1, 32'd5, 32'd7, 32'd0, 1'b1, 1'b0);
    check("sub_valid", {31'd0, out_valid}, 32'd1);
    check("sub_alu", {29'd0, ALUControl}, 32'd1);
    check("sub_srca", SrcA, 32'd5);
    check("sub_srcb", SrcB, 32'd7);
    check("sub_count0", {16'd0, issue_count}, 32'd0);
    idle(1'b1);
    check("sub_count1", {16'd0, issue_count}, 32'd1);

    // ADDI held for three stalled cycles while a new instruction waits
    step(1'b1, OP_I, 3'd0, 1'b1, 32'd10, 32'd99, 32'hFFFF_FFFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, OP_R, 3'd7, 1'b0, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_srcb", SrcB, 32'hFFFF_FFFF);
      check("stall_srca", SrcA, 32'd10);
    end
    step(1'b0, OP_R, 3'd7, 1'b0, 32'd1, 32'd2, 32'd3, 1'b1, 1'b0);
    check("addi_done_valid", {31'd0, out_valid}, 32'd0);
    check("addi_count", {16'd0, issue_count}, 32'd2);

    // Back-to-back BEQ then BNE
    step(1'b1, OP_BR, 3'd0, 1'b0, 32'd4, 32'd4, 32'd0, 1'b1, 1'b0);
    check("beq_bits", {29'd0, is_branch, branch_ne, illegal}, 32'b100);
    step(1'b1, OP_BR, 3'd1, 1'b0, 32'd4, 32'd6, 32'd0, 1'b1, 1'b0);
    check("bne_bits", {29'd0, is_branch, branch_ne, illegal}, 32'b110);
    check("bne_valid", {31'd0, out_valid}, 32'd1);
    check("bne_count", {16'd0, issue_count}, 32'd3);
    idle(1'b1);
    check("br_count", {16'd0, issue_count}, 32'd4);

    // Unsupported JAL opcode still issues, zeroed
    step(1'b1, OP_JAL, 3'd0, 1'b0, 32'd3, 32'd4, 32'd8, 1'b1, 1'b0);
    check("jal_illegal", {31'd0, illegal}, 32'd1);
    check("jal_srca", SrcA, 32'd0);
    check("jal_srcb", SrcB, 32'd0);
    idle(1'b1);
    check("jal_count", {16'd0, issue_count}, 32'd5);

    // Flush: stalled load discarded with accept; then flush during transfer counts it
    step(1'b1, OP_LD, 3'd2, 1'b0, 32'h100, 32'd0, 32'h4, 1'b0, 1'b0);
    step(1'b1, OP_R, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 1'b0, 1'b1);
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_count", {16'd0, issue_count}, 32'd5);
    step(1'b1, OP_ST, 3'd2, 1'b0, 32'h200, 32'd0, 32'h8, 1'b0, 1'b0);
    step(1'b1, OP_R, 3'd0, 1'b0, 32'd1, 32'd1, 32'd0, 1'b1, 1'b1);
    check("flush_xfer_valid", {31'd0, out_valid}, 32'd0);
    check("flush_xfer_count", {16'd0, issue_count}, 32'd6);

    // Mixed instruction table with a fixed back-pressure pattern
    tbl = '{'{OP_R, 3'd7, 1'b0}, '{OP_R, 3'd6, 1'b1}, '{OP_R, 3'd2, 1'b0},
            '{OP_I, 3'd7, 1'b1}, '{OP_I, 3'd6, 1'b0}, '{OP_I, 3'd2, 1'b0},
            '{OP_I, 3'd1, 1'b0}, '{OP_R, 3'd1, 1'b0}, '{OP_BR, 3'd4, 1'b0},
            '{OP_ST, 3'd7, 1'b1}, '{OP_LD, 3'd5, 1'b0}, '{OP_R, 3'd0, 1'b0}};
    for (int i = 0; i < 36; i++) begin
      step((i % 5) != 4, tbl[i % 12].op, tbl[i % 12].f3, tbl[i % 12].f7,
           32'h8000_0000 + i, 32'h10 * i, 32'hFFFF_FF00 + i, (i % 3) != 0, i == 20);
    end
    idle(1'b1);

    // Counter wrap: 16 transfers from reset
    rst_n = 1'b0;
    idle(1'b1);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, OP_I, 3'd0, 1'b0, i, 32'd0, 32'd1, 1'b1, 1'b0);
    end
    idle(1'b1);
    check("wrap_count4", {28'd0, issue_count4}, 32'd0);
    check("wrap_count16", {16'd0, issue_count}, 32'd16);

    // Reset in the middle of a stall with a transfer and accept pending
    step(1'b1, OP_R, 3'd6, 1'b0, 32'hAA, 32'hBB, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b1, OP_R, 3'd0, 1'b0, 32'h1, 32'h2, 32'd0, 1'b1, 1'b0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_srca", SrcA, 32'd0);
    check("midrst_srcb", SrcB, 32'd0);
    check("midrst_ctl", {26'd0, ALUControl, is_branch, branch_ne, illegal}, 32'd0);
    check("midrst_count", {16'd0, issue_count}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    idle(1'b0);
    check("postrst_ready", {31'd0, in_ready}, 32'd1);
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
